// File: rtl/seg6_scan.sv
// seg6_scan: six-digit multiplexed 7-segment scanner with frame snapshot.
// Optional leading-zero blanking is enabled by defining SEG6_LZB_EN.
module seg6_scan #(
    parameter int DIV   = 50000,
    parameter int BLANK = 16
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic [23:0] seg6_export,
    output logic [7:0]  seg_n,
    output logic [5:0]  dig_n
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] BLK  = CW'(BLANK);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [23:0]   snap_q, snap_d;
    logic [7:0]    seg_q, seg_d;
    logic [5:0]    dig_q, dig_d;

    logic          slot_end;
    logic [3:0]    nib;
    logic [6:0]    pat;
    logic          dark;

    assign seg_n = seg_q;
    assign dig_n = dig_q;

    // Hex nibble to gfedcba (active-high) segment pattern.
    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] p;
        case (v)
            4'h0: p = 7'h3F;
            4'h1: p = 7'h06;
            4'h2: p = 7'h5B;
            4'h3: p = 7'h4F;
            4'h4: p = 7'h66;
            4'h5: p = 7'h6D;
            4'h6: p = 7'h7D;
            4'h7: p = 7'h07;
            4'h8: p = 7'h7F;
            4'h9: p = 7'h6F;
            4'hA: p = 7'h77;
            4'hB: p = 7'h7C;
            4'hC: p = 7'h39;
            4'hD: p = 7'h5E;
            4'hE: p = 7'h79;
            default: p = 7'h71;
        endcase
        return p;
    endfunction

    // Counter/index/snapshot advance and registered display drive.
    always_comb begin
        slot_end = (cnt_q == LAST);
        cnt_d    = slot_end ? '0 : cnt_q + 1'b1;
        idx_d    = idx_q;
        snap_d   = snap_q;
        if (slot_end) begin
            idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
            if (idx_q == 3'd5) begin
                snap_d = seg6_export;
            end
        end

        nib = snap_q[{idx_q, 2'b00} +: 4];
        pat = hex7(nib);
`ifdef SEG6_LZB_EN
        // A digit with only zeros at and above it is dark; digit 0 always shows.
        if (idx_q != 3'd0 && (snap_q >> {idx_q, 2'b00}) == 24'd0) begin
            pat = 7'h00;
        end
`endif
        seg_d = {1'b1, ~pat};

        dark  = (cnt_q < BLK);
        dig_d = dark ? 6'h3F : ~(6'b000001 << idx_q);
    end

    // State registers; reset drops everything dark immediately.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            cnt_q  <= '0;
            idx_q  <= 3'd0;
            snap_q <= 24'd0;
            seg_q  <= 8'hFF;
            dig_q  <= 6'h3F;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            snap_q <= snap_d;
            seg_q  <= seg_d;
            dig_q  <= dig_d;
        end
    end

endmodule

// File: tb/tb_seg6_scan.sv
// tb_seg6_scan: directed bench for seg6_scan (DIV=8, BLANK=2)
// with a time-based display model and literal spot checks.
module tb_seg6_scan;

    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int FRAME = 6 * DIV;

    logic        clk;
    logic        rst;
    logic [23:0] val;
    logic [7:0]  seg_n;
    logic [5:0]  dig_n;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    seg6_scan #(.DIV(DIV), .BLANK(BLANK)) dut (
        .clk_clk    (clk),
        .reset_reset(rst),
        .seg6_export(val),
        .seg_n      (seg_n),
        .dig_n      (dig_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] pat [0:15] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Model: t counts cycles since release; frame value latched at frame end.
    int          t;
    logic [23:0] m_snap;
    logic [7:0]  e_seg;
    logic [5:0]  e_dig;
    logic [7:0]  prev_seg;
    logic        lzb;

    initial begin
`ifdef SEG6_LZB_EN
        lzb = 1'b1;
`else
        lzb = 1'b0;
`endif
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            t      = 0;
            cyc    = 0;
            m_snap = 24'd0;
            e_seg  = 8'hFF;
            e_dig  = 6'h3F;
        end else begin
            int c, k;
            logic [3:0] nb;
            c  = t % DIV;
            k  = (t / DIV) % 6;
            nb = 4'((m_snap >> (4 * k)) & 24'hF);
            if (lzb && k > 0 && (m_snap >> (4 * k)) == 24'd0)
                e_seg = 8'hFF;
            else
                e_seg = {1'b1, ~pat[nb]};
            e_dig = (c < BLANK) ? 6'h3F : ~(6'(1) << k);
            if (t % FRAME == FRAME - 1) m_snap = val;
            t   = t + 1;
            cyc = cyc + 1;
        end
    end

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at cyc %0d: got %h want %h", nm, cyc, got, exp);
        end
    endtask

    // Compare process: model, one-hot, and seg-change-only-when-dark.
    initial prev_seg = 8'hFF;
    always @(negedge clk) begin
        chk("seg_model", seg_n, e_seg);
        chk("dig_model", {2'b0, dig_n}, {2'b0, e_dig});
        chk("dig_onehot", {7'b0, ($countones(~dig_n) <= 1)}, 8'd1);
        if (seg_n !== prev_seg)
            chk("seg_chg_dark", {2'b0, dig_n}, 8'h3F);
        prev_seg = seg_n;
    end

    task automatic at_cyc(input int n);
        int b;
        b = 0;
        while (cyc != n && b < 2000) begin
            @(negedge clk);
            b++;
        end
        if (cyc != n) begin
            n_bad++;
            $display("FAIL timeout waiting cyc %0d: got %0d", n, cyc);
        end
    endtask

    initial begin
        rst = 1'b1;
        val = 24'h123456;
        #1;
        chk("rst_seg", seg_n, 8'hFF);
        chk("rst_dig", {2'b0, dig_n}, 8'h3F);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        at_cyc(1);
        chk("c1_dig", {2'b0, dig_n}, 8'h3F);
        at_cyc(2);
        chk("c2_dig", {2'b0, dig_n}, 8'h3F);
        at_cyc(3);
        chk("c3_dig", {2'b0, dig_n}, 8'h3E);
        chk("c3_seg", seg_n, 8'hC0);
        at_cyc(8);
        chk("c8_seg", seg_n, 8'hC0);

        at_cyc(52);
        chk("f2_d0_seg", seg_n, 8'h82);
        chk("f2_d0_dig", {2'b0, dig_n}, 8'h3E);
        at_cyc(92);
        chk("f2_d5_seg", seg_n, 8'hF9);
        chk("f2_d5_dig", {2'b0, dig_n}, 8'h1F);

        at_cyc(100);
        val = 24'hABCDEF;
        at_cyc(140);
        chk("f3_d5_old", seg_n, 8'hF9);
        at_cyc(148);
        chk("f4_d0_F", seg_n, 8'h8E);
        at_cyc(188);
        chk("f4_d5_A", seg_n, 8'h88);

        at_cyc(195);
        val = 24'h000042;
        at_cyc(244);
        chk("z42_d0", seg_n, 8'hA4);
        at_cyc(252);
        chk("z42_d1", seg_n, 8'h99);
        at_cyc(260);
        chk("z42_d2", seg_n, lzb ? 8'hFF : 8'hC0);
        at_cyc(290);
        val = 24'h000000;
        at_cyc(340);
        chk("z0_d0", seg_n, 8'hC0);
        at_cyc(364);
        chk("z0_d3", seg_n, lzb ? 8'hFF : 8'hC0);

        at_cyc(412);
        chk("pre_rst_dig", {2'b0, dig_n}, 8'h37);
        #1 rst = 1'b1;
        #1;
        chk("async_dig", {2'b0, dig_n}, 8'h3F);
        chk("async_seg", seg_n, 8'hFF);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        val = 24'h987654;
        at_cyc(3);
        chk("rr_c3_dig", {2'b0, dig_n}, 8'h3E);
        chk("rr_c3_seg", seg_n, 8'hC0);
        at_cyc(52);
        chk("rr_f2_d0", seg_n, 8'h99);
        at_cyc(60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
